usb_ctl_setup_decoder: RTL and testbench
========================================

// Module: usb_ctl_setup_decoder
// PURPOSE
//  Control-pipe initiator feeding the EP0 standard/vendor request responders. Receives the 8-byte
//  SETUP DATA0 payload (CRC already checked/stripped) as an AXI-S byte stream, decodes the fields,
//  presents them stably, raises ctl_xfer_req, and tracks grant/completion. Sits between the USB
//  packet decoder and the request responders on endpoint 0.
// PARAMETERS
//  TIMEOUT  16  cycles to wait for ctl_xfer_gnt_i after req rises (used only with CTL_REQ_TIMEOUT_EN)
// PORTS
//  clock                  in   1   system clock; all logic on posedge
//  reset                  in   1   synchronous, active-high
//  setup_endpoint_i       in   4   endpoint of the SETUP token, valid with first beat
//  setup_tvalid_i         in   1   SETUP payload byte valid
//  setup_tready_o         out  1   payload ready
//  setup_tlast_i          in   1   last payload byte
//  setup_tdata_i          in   8   payload byte
//  ctl_xfer_endpoint      out  4   decoded endpoint
//  ctl_xfer_type          out  8   bmRequestType
//  ctl_xfer_request       out  8   bRequest
//  ctl_xfer_value         out  16  wValue
//  ctl_xfer_index         out  16  wIndex
//  ctl_xfer_length        out  16  wLength
//  ctl_xfer_req_o         out  1   request active
//  ctl_xfer_gnt_i         in   1   responder accepts request
//  ctl_xfer_done_i        in   1   status stage complete (1-cycle pulse from transaction layer)
//  ctl_stall_o            out  1   no responder; EP0 must STALL data/status stage
//  setup_error_o          out  1   1-cycle pulse: malformed SETUP discarded
// BEHAVIOUR
//  - Reset: all ctl_xfer_* fields 0, req/stall/error 0, setup_tready_o 0 during reset, state IDLE.
//  - setup_tready_o = 1 whenever not in reset (a SETUP is never refused; USB mandates ACK).
//  - Byte order: b0 type, b1 request, b2/b3 wValue LSB/MSB, b4/b5 wIndex, b6/b7 wLength.
//  - Bytes land in shadow regs via 3-bit counter; outputs update only on commit (good packet),
//    so fields are stable for the whole time req is high.
//  - States: IDLE, RECV, REQ, BUSY, STALL.
//  - IDLE/REQ/BUSY/STALL + first beat: drop req and stall same edge, latch endpoint, count=1, ->RECV
//    (new SETUP always aborts any transfer in progress).
//  - RECV: tlast with count==7 -> commit fields, ->REQ; req_o high the cycle after the last beat.
//    tlast with count<7 (short) or beat at count==7 without tlast (long) -> error pulse, fields
//    unchanged, ->IDLE; for long packets drop remaining beats until tlast.
//  - REQ: req_o=1; gnt_i=1 ->BUSY. gnt may arrive 1+ cycles after req (responders register it).
//  - BUSY: req_o=1 until done_i ->IDLE (req low next cycle). gnt_i dropping in BUSY is ignored.
//  - STALL: stall_o=1, req_o=0; held until next SETUP first beat (->RECV) or reset.
//  - done_i outside BUSY ignored. gnt_i outside REQ/BUSY ignored.
//  - Simultaneous done_i and new SETUP beat: SETUP wins (->RECV).
//  - Reset mid-packet: partial shadow contents discarded, state IDLE.
// CONFIGURATION
//  CTL_REQ_TIMEOUT_EN defined: counter starts on entering REQ; TIMEOUT cycles with no gnt_i ->
//    STALL (req drops). Counter cleared on every REQ entry.
//  Not defined: REQ waits indefinitely for gnt_i; STALL state unreachable, stall_o tied 0.
// TESTING
//  - GET_DESCRIPTOR: bytes 80 06 00 01 00 00 40 00 -> type=80 req=06 value=0100 length=0040,
//    req_o up 1 cycle after tlast; gnt after 1 cycle -> BUSY; done pulse -> req_o low next cycle.
//  - SET_ADDRESS 00 05 2A 00 00 00 00 00 with tvalid gaps -> value=002A, fields stable while req_o=1.
//  - Short packet (tlast on byte 5) and 9-byte packet -> setup_error_o one pulse each, no req_o,
//    outputs keep previous values.
//  - New SETUP arriving during BUSY (before done) -> req_o drops on first beat, new fields
//    committed, req_o reasserts after its tlast.
//  - CTL_REQ_TIMEOUT_EN, TIMEOUT=16, vendor request C0 51 ... never granted -> stall_o high at
//    cycle 16 after req, stays high until next SETUP; without macro req_o stays high, stall_o=0.
//  - Reset asserted at byte 3 -> all outputs 0 next cycle; following full SETUP decodes correctly.

Source files
------------

// File: rtl/usb_ctl_setup_decoder_if.sv
// ---------------------------------------------------------------------------
// usb_ctl_setup_decoder_if
//   Bundle of the SETUP payload stream (AXI-S style byte stream from the USB
//   packet decoder) and the decoded control-transfer request presented to the
//   EP0 request responders.
//
//   Signals
//     setup_endpoint_i  4   endpoint of the SETUP token, valid with first beat
//     setup_tvalid_i    1   payload byte valid
//     setup_tready_o    1   payload ready
//     setup_tlast_i     1   last payload byte
//     setup_tdata_i     8   payload byte
//     ctl_xfer_endpoint 4   decoded endpoint
//     ctl_xfer_type     8   bmRequestType
//     ctl_xfer_request  8   bRequest
//     ctl_xfer_value    16  wValue
//     ctl_xfer_index    16  wIndex
//     ctl_xfer_length   16  wLength
//     ctl_xfer_req_o    1   request active
//     ctl_xfer_gnt_i    1   responder accepts request
//     ctl_xfer_done_i   1   status stage complete (1-cycle pulse)
//     ctl_stall_o       1   no responder; EP0 must STALL data/status stage
//     setup_error_o     1   1-cycle pulse: malformed SETUP discarded
//
//   Modports
//     slave  : the setup decoder (consumes the stream, drives the request)
//     master : the environment (packet decoder + responders + transaction layer)
// ---------------------------------------------------------------------------
interface usb_ctl_setup_decoder_if;
   logic [3:0]  setup_endpoint_i;
   logic        setup_tvalid_i;
   logic        setup_tready_o;
   logic        setup_tlast_i;
   logic [7:0]  setup_tdata_i;
   logic [3:0]  ctl_xfer_endpoint;
   logic [7:0]  ctl_xfer_type;
   logic [7:0]  ctl_xfer_request;
   logic [15:0] ctl_xfer_value;
   logic [15:0] ctl_xfer_index;
   logic [15:0] ctl_xfer_length;
   logic        ctl_xfer_req_o;
   logic        ctl_xfer_gnt_i;
   logic        ctl_xfer_done_i;
   logic        ctl_stall_o;
   logic        setup_error_o;

   modport slave (
      input  setup_endpoint_i,
      input  setup_tvalid_i,
      output setup_tready_o,
      input  setup_tlast_i,
      input  setup_tdata_i,
      output ctl_xfer_endpoint,
      output ctl_xfer_type,
      output ctl_xfer_request,
      output ctl_xfer_value,
      output ctl_xfer_index,
      output ctl_xfer_length,
      output ctl_xfer_req_o,
      input  ctl_xfer_gnt_i,
      input  ctl_xfer_done_i,
      output ctl_stall_o,
      output setup_error_o
   );

   modport master (
      output setup_endpoint_i,
      output setup_tvalid_i,
      input  setup_tready_o,
      output setup_tlast_i,
      output setup_tdata_i,
      input  ctl_xfer_endpoint,
      input  ctl_xfer_type,
      input  ctl_xfer_request,
      input  ctl_xfer_value,
      input  ctl_xfer_index,
      input  ctl_xfer_length,
      input  ctl_xfer_req_o,
      output ctl_xfer_gnt_i,
      output ctl_xfer_done_i,
      input  ctl_stall_o,
      input  setup_error_o
   );
endinterface

// File: rtl/usb_ctl_setup_decoder.sv
// ---------------------------------------------------------------------------
// usb_ctl_setup_decoder
//   Control-pipe initiator for endpoint 0. Collects the 8-byte SETUP payload
//   (CRC already stripped) from a byte stream, decodes bmRequestType,
//   bRequest, wValue, wIndex and wLength, presents them stably and raises
//   ctl_xfer_req_o until the responder grants and the transaction layer
//   reports the status stage complete.
//
//   Ports
//     clock  in  system clock, all logic on posedge
//     reset  in  synchronous, active-high
//     bus    slave modport of usb_ctl_setup_decoder_if (stream + request)
//
//   Parameters
//     TIMEOUT  cycles to wait for a grant before stalling (only used when
//              CTL_REQ_TIMEOUT_EN is defined)
//
//   Build option
//     CTL_REQ_TIMEOUT_EN  when defined, a request not granted within TIMEOUT
//                         cycles moves to STALL and ctl_stall_o rises. When
//                         undefined, a request waits for its grant forever
//                         and ctl_stall_o is constant 0.
//
//   Payload byte order: b0 type, b1 request, b2/b3 wValue LSB/MSB,
//   b4/b5 wIndex LSB/MSB, b6/b7 wLength LSB/MSB.
// ---------------------------------------------------------------------------
module usb_ctl_setup_decoder #(
   parameter int TIMEOUT = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   usb_ctl_setup_decoder_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_REQ   = 3'd2,
      ST_BUSY  = 3'd3,
      ST_STALL = 3'd4
   } state_e;

   // A zero-cycle grant window is meaningless for the timeout counter.
   if (TIMEOUT < 1) begin : g_timeout_range_check
      $error("usb_ctl_setup_decoder: TIMEOUT must be at least 1");
   end

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;         // index of the next payload byte
   logic            drop_q, drop_d;       // swallowing the tail of an oversize packet
   logic [3:0]      ep_sh_q, ep_sh_d;     // endpoint captured with the first beat
   logic [6:0][7:0] sh_q, sh_d;           // shadow bytes 0..6; byte 7 comes straight off the bus at commit

   logic            tready_q, tready_d;
   logic [3:0]      ep_q, ep_d;
   logic [7:0]      type_q, type_d;
   logic [7:0]      request_q, request_d;
   logic [15:0]     value_q, value_d;
   logic [15:0]     index_q, index_d;
   logic [15:0]     length_q, length_d;
   logic            req_q, req_d;
   logic            stall_q, stall_d;
   logic            err_q, err_d;

   logic            beat_s;

`ifdef CTL_REQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   // A payload byte transfers only when the decoder is advertising ready.
   assign beat_s = bus.setup_tvalid_i & tready_q;

   // Next-state, shadow capture, commit and output decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      drop_d    = drop_q;
      ep_sh_d   = ep_sh_q;
      sh_d      = sh_q;
      tready_d  = 1'b1;
      ep_d      = ep_q;
      type_d    = type_q;
      request_d = request_q;
      value_d   = value_q;
      index_d   = index_q;
      length_d  = length_q;
      err_d     = 1'b0;
`ifdef CTL_REQ_TIMEOUT_EN
      tmo_d     = tmo_q;
`endif

      case (state_q)
         ST_RECV: begin
            if (beat_s) begin
               if (bus.setup_tlast_i) begin
                  if (cnt_q == 3'd7) begin
                     // Good 8-byte packet: publish every field on the same edge.
                     ep_d      = ep_sh_q;
                     type_d    = sh_q[0];
                     request_d = sh_q[1];
                     value_d   = {sh_q[3], sh_q[2]};
                     index_d   = {sh_q[5], sh_q[4]};
                     length_d  = {bus.setup_tdata_i, sh_q[6]};
                     state_d   = ST_REQ;
`ifdef CTL_REQ_TIMEOUT_EN
                     tmo_d     = TMO_W'(0);
`endif
                  end else begin
                     // Short packet: discard, published fields untouched.
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else if (cnt_q == 3'd7) begin
                  // Ninth byte is coming: discard and ignore beats up to tlast.
                  err_d   = 1'b1;
                  drop_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  for (int i = 0; i < 7; i++) begin
                     if (cnt_q == 3'(i)) begin
                        sh_d[i] = bus.setup_tdata_i;
                     end else begin
                        sh_d[i] = sh_q[i];
                     end
                  end
                  cnt_d = cnt_q + 3'd1;
               end
            end else begin
               state_d = ST_RECV;
            end
         end

         ST_IDLE, ST_REQ, ST_BUSY, ST_STALL: begin
            if (beat_s && drop_q) begin
               drop_d = ~bus.setup_tlast_i;
            end else if (beat_s) begin
               // First beat of a new SETUP aborts whatever was in progress;
               // it takes priority over a coincident grant or done pulse.
               ep_sh_d = bus.setup_endpoint_i;
               sh_d[0] = bus.setup_tdata_i;
               cnt_d   = 3'd1;
               if (bus.setup_tlast_i) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RECV;
               end
            end else if (state_q == ST_REQ) begin
               if (bus.ctl_xfer_gnt_i) begin
                  state_d = ST_BUSY;
`ifdef CTL_REQ_TIMEOUT_EN
               end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  state_d = ST_STALL;
               end else begin
                  tmo_d   = tmo_q + TMO_W'(1);
                  state_d = ST_REQ;
               end
`else
               end else begin
                  state_d = ST_REQ;
               end
`endif
            end else if (state_q == ST_BUSY) begin
               // Grant level is irrelevant here; only completion matters.
               if (bus.ctl_xfer_done_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_BUSY;
               end
            end else begin
               state_d = state_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            drop_d  = 1'b0;
         end
      endcase

      // Handshake outputs are registered images of the next state.
      req_d = (state_d == ST_REQ) || (state_d == ST_BUSY);
`ifdef CTL_REQ_TIMEOUT_EN
      stall_d = (state_d == ST_STALL);
`else
      stall_d = 1'b0;
`endif
   end

   // State, shadow and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 3'd0;
         drop_q    <= 1'b0;
         ep_sh_q   <= 4'd0;
         sh_q      <= 56'd0;
         tready_q  <= 1'b0;
         ep_q      <= 4'd0;
         type_q    <= 8'd0;
         request_q <= 8'd0;
         value_q   <= 16'd0;
         index_q   <= 16'd0;
         length_q  <= 16'd0;
         req_q     <= 1'b0;
         stall_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         drop_q    <= drop_d;
         ep_sh_q   <= ep_sh_d;
         sh_q      <= sh_d;
         tready_q  <= tready_d;
         ep_q      <= ep_d;
         type_q    <= type_d;
         request_q <= request_d;
         value_q   <= value_d;
         index_q   <= index_d;
         length_q  <= length_d;
         req_q     <= req_d;
         stall_q   <= stall_d;
         err_q     <= err_d;
      end
   end

`ifdef CTL_REQ_TIMEOUT_EN
   // Grant-wait counter, restarted on every entry into REQ.
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_q <= TMO_W'(0);
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign bus.setup_tready_o    = tready_q;
   assign bus.ctl_xfer_endpoint = ep_q;
   assign bus.ctl_xfer_type     = type_q;
   assign bus.ctl_xfer_request  = request_q;
   assign bus.ctl_xfer_value    = value_q;
   assign bus.ctl_xfer_index    = index_q;
   assign bus.ctl_xfer_length   = length_q;
   assign bus.ctl_xfer_req_o    = req_q;
   assign bus.ctl_stall_o       = stall_q;
   assign bus.setup_error_o     = err_q;

endmodule

// File: tb/tb_usb_ctl_setup_decoder.sv
// ---------------------------------------------------------------------------
// tb_usb_ctl_setup_decoder
//   Self-checking bench for usb_ctl_setup_decoder. Directed SETUP scenarios
//   followed by randomized packets (good, short, oversize) with random grant/
//   completion/abort sequences, compared against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_usb_ctl_setup_decoder;
   localparam int TIMEOUT = 16;

   logic clock = 1'b0;
   logic reset;

   usb_ctl_setup_decoder_if bus_if ();

   usb_ctl_setup_decoder #(.TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  ep;
      logic [7:0]  typ;
      logic [7:0]  rq;
      logic [15:0] val;
      logic [15:0] idx;
      logic [15:0] len;
   } fields_t;

   int      n_cmp = 0;
   int      n_mis = 0;
   int      err_seen = 0;
   int      stab_err = 0;
   int      exp_err = 0;
   fields_t exp_f;
   bit      exp_req;
   bit      exp_stall;

   logic [67:0] cur_fields;
   logic [67:0] prev_fields = 68'd0;
   logic        prev_req = 1'b0;

   assign cur_fields = {bus_if.ctl_xfer_endpoint, bus_if.ctl_xfer_type, bus_if.ctl_xfer_request,
                        bus_if.ctl_xfer_value, bus_if.ctl_xfer_index, bus_if.ctl_xfer_length};

   // Count error pulses and flag any field change while the request stays up.
   always @(posedge clock) begin
      if (bus_if.setup_error_o === 1'b1) err_seen <= err_seen + 1;
      if (prev_req && (bus_if.ctl_xfer_req_o === 1'b1) && (cur_fields !== prev_fields))
         stab_err <= stab_err + 1;
      prev_req    <= bus_if.ctl_xfer_req_o;
      prev_fields <= cur_fields;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Reference model: a good packet publishes its bytes as little-endian fields.
   function automatic void model_good(input logic [7:0] b[$], input logic [3:0] ep);
      exp_f.ep  = ep;
      exp_f.typ = b[0];
      exp_f.rq  = b[1];
      exp_f.val = 16'(b[2]) + 16'(b[3]) * 16'd256;
      exp_f.idx = 16'(b[4]) + 16'(b[5]) * 16'd256;
      exp_f.len = 16'(b[6]) + 16'(b[7]) * 16'd256;
      exp_req   = 1'b1;
      exp_stall = 1'b0;
   endfunction

   // A malformed packet changes nothing published, cancels any request, one error pulse.
   function automatic void model_bad();
      exp_err   = exp_err + 1;
      exp_req   = 1'b0;
      exp_stall = 1'b0;
   endfunction

   task automatic check_fields();
      check_eq("endpoint", 32'(bus_if.ctl_xfer_endpoint), 32'(exp_f.ep));
      check_eq("type",     32'(bus_if.ctl_xfer_type),     32'(exp_f.typ));
      check_eq("request",  32'(bus_if.ctl_xfer_request),  32'(exp_f.rq));
      check_eq("value",    32'(bus_if.ctl_xfer_value),    32'(exp_f.val));
      check_eq("index",    32'(bus_if.ctl_xfer_index),    32'(exp_f.idx));
      check_eq("length",   32'(bus_if.ctl_xfer_length),   32'(exp_f.len));
      check_eq("req",      32'(bus_if.ctl_xfer_req_o),    32'(exp_req));
      check_eq("stall",    32'(bus_if.ctl_stall_o),       32'(exp_stall));
   endtask

   task automatic send_pkt(input logic [7:0] b[$], input logic [3:0] ep, input bit gaps,
                           input bit done_first);
      for (int i = 0; i < b.size(); i++) begin
         if (gaps && i > 0) begin
            bus_if.setup_tvalid_i = 1'b0;
            tick($urandom_range(1, 2));
         end
         bus_if.setup_tvalid_i   = 1'b1;
         bus_if.setup_tdata_i    = b[i];
         bus_if.setup_tlast_i    = (i == b.size() - 1);
         bus_if.setup_endpoint_i = (i == 0) ? ep : 4'($urandom);
         bus_if.ctl_xfer_done_i  = (i == 0) && done_first;
         tick(1);
         bus_if.ctl_xfer_done_i  = 1'b0;
         if (i == 0) begin
            check_eq("first_beat_req",   32'(bus_if.ctl_xfer_req_o), 32'd0);
            check_eq("first_beat_stall", 32'(bus_if.ctl_stall_o),    32'd0);
         end
      end
      bus_if.setup_tvalid_i = 1'b0;
      bus_if.setup_tlast_i  = 1'b0;
   endtask

   task automatic run_setup(input logic [7:0] b[$], input logic [3:0] ep, input bit gaps,
                            input bit done_first);
      send_pkt(b, ep, gaps, done_first);
      if (b.size() == 8) model_good(b, ep);
      else model_bad();
      check_fields();
      tick(1);
      check_eq("error_pulses", 32'(err_seen), 32'(exp_err));
   endtask

   task automatic grant_and_done(input int k, input int m);
      tick(k);
      bus_if.ctl_xfer_gnt_i = 1'b1;
      tick(1);
      bus_if.ctl_xfer_gnt_i = 1'b0;
      tick(m);
      check_eq("busy_req", 32'(bus_if.ctl_xfer_req_o), 32'd1);
      bus_if.ctl_xfer_done_i = 1'b1;
      tick(1);
      bus_if.ctl_xfer_done_i = 1'b0;
      exp_req = 1'b0;
      check_eq("done_req", 32'(bus_if.ctl_xfer_req_o), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] pkt[$];
      logic [3:0] ep;
      bit         done_first;
      int         len;
      int         kind;
      int         mode;

      reset = 1'b1;
      bus_if.setup_endpoint_i = 4'd0;
      bus_if.setup_tvalid_i   = 1'b0;
      bus_if.setup_tlast_i    = 1'b0;
      bus_if.setup_tdata_i    = 8'd0;
      bus_if.ctl_xfer_gnt_i   = 1'b0;
      bus_if.ctl_xfer_done_i  = 1'b0;
      exp_f     = '{ep: 4'd0, typ: 8'd0, rq: 8'd0, val: 16'd0, idx: 16'd0, len: 16'd0};
      exp_req   = 1'b0;
      exp_stall = 1'b0;

      // Reset state
      tick(3);
      check_fields();
      check_eq("reset_tready", 32'(bus_if.setup_tready_o), 32'd0);
      check_eq("reset_error",  32'(bus_if.setup_error_o),  32'd0);
      reset = 1'b0;
      tick(2);
      check_eq("tready", 32'(bus_if.setup_tready_o), 32'd1);

      // GET_DESCRIPTOR, grant one cycle later, then completion
      pkt = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
      run_setup(pkt, 4'h0, 1'b0, 1'b0);
      grant_and_done(0, 2);

      // gnt/done while idle are ignored
      bus_if.ctl_xfer_gnt_i  = 1'b1;
      bus_if.ctl_xfer_done_i = 1'b1;
      tick(1);
      bus_if.ctl_xfer_gnt_i  = 1'b0;
      bus_if.ctl_xfer_done_i = 1'b0;
      tick(1);
      check_eq("idle_ignore_req", 32'(bus_if.ctl_xfer_req_o), 32'd0);

      // SET_ADDRESS with tvalid gaps
      pkt = '{8'h00, 8'h05, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_setup(pkt, 4'h0, 1'b1, 1'b0);
      grant_and_done(2, 3);

      // Short packet (tlast on byte 5) and 9-byte packet
      pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      run_setup(pkt, 4'h3, 1'b0, 1'b0);
      pkt = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98, 8'h99};
      run_setup(pkt, 4'h5, 1'b1, 1'b0);

      // New SETUP during BUSY, with a coincident done on its first beat
      pkt = '{8'h21, 8'h09, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      run_setup(pkt, 4'h0, 1'b0, 1'b0);
      bus_if.ctl_xfer_gnt_i = 1'b1;
      tick(1);
      bus_if.ctl_xfer_gnt_i = 1'b0;
      tick(2);
      pkt = '{8'hA1, 8'h01, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
      run_setup(pkt, 4'h0, 1'b0, 1'b1);
      grant_and_done(1, 1);

      // Vendor request never granted
      pkt = '{8'hC0, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
      run_setup(pkt, 4'h0, 1'b0, 1'b0);
      tick(TIMEOUT - 2);
      check_eq("pre_timeout_req",   32'(bus_if.ctl_xfer_req_o), 32'd1);
      check_eq("pre_timeout_stall", 32'(bus_if.ctl_stall_o),    32'd0);
      tick(1);
`ifdef CTL_REQ_TIMEOUT_EN
      exp_req   = 1'b0;
      exp_stall = 1'b1;
      check_fields();
      tick(5);
      check_eq("stall_held", 32'(bus_if.ctl_stall_o), 32'd1);
`else
      check_fields();
      tick(5);
      check_eq("req_held", 32'(bus_if.ctl_xfer_req_o), 32'd1);
`endif

      // Reset asserted while byte 3 is on the bus
      pkt = '{8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFF, 8'h00};
      for (int i = 0; i < 3; i++) begin
         bus_if.setup_tvalid_i   = 1'b1;
         bus_if.setup_tdata_i    = pkt[i];
         bus_if.setup_tlast_i    = 1'b0;
         bus_if.setup_endpoint_i = 4'h7;
         tick(1);
      end
      bus_if.setup_tdata_i = pkt[3];
      reset = 1'b1;
      tick(1);
      bus_if.setup_tvalid_i = 1'b0;
      exp_f     = '{ep: 4'd0, typ: 8'd0, rq: 8'd0, val: 16'd0, idx: 16'd0, len: 16'd0};
      exp_req   = 1'b0;
      exp_stall = 1'b0;
      check_fields();
      check_eq("rst_tready", 32'(bus_if.setup_tready_o), 32'd0);
      check_eq("rst_error",  32'(bus_if.setup_error_o),  32'd0);
      reset = 1'b0;
      tick(2);
      run_setup(pkt, 4'h7, 1'b0, 1'b0);
      grant_and_done(0, 0);

      // Randomized packets and handshakes
      done_first = 1'b0;
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 9);
         if (kind < 7) len = 8;
         else if (kind == 7) len = $urandom_range(1, 7);
         else len = $urandom_range(9, 12);
         pkt.delete();
         for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
         ep = 4'($urandom);
         run_setup(pkt, ep, 1'($urandom_range(0, 1)), done_first);
         done_first = 1'b0;
         if (len == 8) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
               grant_and_done($urandom_range(0, 3), $urandom_range(0, 3));
            end else if (mode == 2) begin
               tick($urandom_range(0, 2));
               bus_if.ctl_xfer_gnt_i = 1'b1;
               tick(1);
               bus_if.ctl_xfer_gnt_i = 1'b0;
               tick($urandom_range(0, 2));
               check_eq("busy_hold_req", 32'(bus_if.ctl_xfer_req_o), 32'd1);
               done_first = 1'($urandom_range(0, 1));
            end else begin
               tick($urandom_range(0, 3));
               check_eq("req_wait", 32'(bus_if.ctl_xfer_req_o), 32'd1);
            end
         end else begin
            bus_if.ctl_xfer_gnt_i  = 1'b1;
            bus_if.ctl_xfer_done_i = 1'b1;
            tick(1);
            bus_if.ctl_xfer_gnt_i  = 1'b0;
            bus_if.ctl_xfer_done_i = 1'b0;
            check_eq("bad_no_req", 32'(bus_if.ctl_xfer_req_o), 32'd0);
         end
      end

      tick(2);
      check_eq("field_stability", 32'(stab_err), 32'd0);
      check_eq("error_total", 32'(err_seen), 32'(exp_err));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
